seg_scan_sched: RTL and testbench

Scan scheduler for the 6-digit multiplexed 7-segment display driven through the 74HC595 shift controller.
- Holds a coherent snapshot of six hex/BCD digits plus decimal points.
- Steps one digit at a time, producing the sel/seg frame for each.
- Hands each frame to the HC595 shift controller over a req/ack handshake.
- Paces digits with a programmable dwell counter.
- Replaces a fixed free-running digit source, so display timing follows shifter completion.

---
 rtl/seg_scan_sched.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_sched.sv
// Digit scan scheduler for a multiplexed 7-segment display behind an HC595 shifter.
// Snapshots the digit data, decodes one digit per frame and paces frames with a dwell counter.
module seg_scan_sched #(
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  blank_lz,
    input  logic                  ack,
    output logic                  req,
    output logic [DIGITS-1:0]     sel,
    output logic [7:0]            seg,
    output logic                  busy
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DW    = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_HOLD
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               req_q;
    logic [DIGITS-1:0]  sel_q;
    logic [7:0]         seg_q;
    logic               busy_q;
    logic [DW-1:0]      sh_data_q;
    logic [DIGITS-1:0]  sh_dp_q;
    logic               sh_blz_q;

    logic [DIGITS-1:0]  sel_d;
    logic [7:0]         seg_d;
    logic [3:0]         nib;
    logic               dp_on;
    logic               lz_blank;
    logic               upper_zero;

    assign req  = req_q;
    assign sel  = sel_q;
    assign seg  = seg_q;
    assign busy = busy_q;

    // Frame for the current index, from shadow values only; upper_zero accumulates from the MSD down
    always_comb begin
        nib        = 4'd0;
        dp_on      = 1'b0;
        lz_blank   = 1'b0;
        upper_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (sh_data_q[4*k +: 4] == 4'd0);
            if (IDX_W'(k) == idx_q) begin
                nib      = sh_data_q[4*k +: 4];
                dp_on    = sh_dp_q[k];
                lz_blank = sh_blz_q && (k != 0) && upper_zero;
            end
        end
        sel_d = DIGITS'(1) << idx_q;
        case (nib)
            4'h0:    seg_d = 8'hC0;
            4'h1:    seg_d = 8'hF9;
            4'h2:    seg_d = 8'hA4;
            4'h3:    seg_d = 8'hB0;
            4'h4:    seg_d = 8'h99;
            4'h5:    seg_d = 8'h92;
            4'h6:    seg_d = 8'h82;
            4'h7:    seg_d = 8'hF8;
            4'h8:    seg_d = 8'h80;
            4'h9:    seg_d = 8'h90;
            4'hA:    seg_d = 8'h88;
            4'hB:    seg_d = 8'h83;
            4'hC:    seg_d = 8'hC6;
            4'hD:    seg_d = 8'hA1;
            4'hE:    seg_d = 8'h86;
            default: seg_d = 8'h8E;
        endcase
        if (lz_blank) begin
            seg_d[6:0] = 7'h7F;
        end
        seg_d[7] = ~dp_on;
    end

    // Scan FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            sel_q     <= '0;
            seg_q     <= 8'hFF;
            busy_q    <= 1'b0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_blz_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_q     <= 1'b0;
                    sel_q     <= '0;
                    seg_q     <= 8'hFF;
                    idx_q     <= '0;
                    cnt_q     <= '0;
                    sh_data_q <= data;
                    sh_dp_q   <= dp_mask;
                    sh_blz_q  <= blank_lz;
                    if (en) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        sel_q   <= sel_d;
                        seg_q   <= seg_d;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // A dropped enable only takes effect once the shifter has latched the frame
                    if (ack) begin
                        req_q <= 1'b0;
                        cnt_q <= '0;
                        if (en) begin
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                        if (idx_q == IDX_W'(DIGITS - 1)) begin
                            idx_q     <= '0;
                            sh_data_q <= data;
                            sh_dp_q   <= dp_mask;
                            sh_blz_q  <= blank_lz;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched: directed scenarios plus randomized digit data,
// checked against a frame-level reference of the display snapshot.
module tb_seg_scan_sched;

    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] data;
    logic [5:0]  dp_mask;
    logic        blank_lz;
    logic        ack;
    logic        req;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    // Reference view: the snapshot the display should be showing and the digit expected next
    logic [23:0] snap_data;
    logic [5:0]  snap_dp;
    logic        snap_blz;
    int          exp_idx;

    localparam logic [7:0] HEX7 [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg_scan_sched #(
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data    (data),
        .dp_mask (dp_mask),
        .blank_lz(blank_lz),
        .ack     (ack),
        .req     (req),
        .sel     (sel),
        .seg     (seg),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_seg(input int k);
        logic [7:0] s;
        if (snap_blz && k > 0 && (snap_data >> (4 * k)) == 24'd0) s = 8'hFF;
        else s = HEX7[snap_data[4*k +: 4]];
        if (snap_dp[k]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic take_snap();
        snap_data = data;
        snap_dp   = dp_mask;
        snap_blz  = blank_lz;
    endtask

    task automatic start_scan();
        take_snap();
        exp_idx = 0;
        en      = 1'b1;
    endtask

    // Wait for a request, check its frame and timing, then acknowledge after ack_dly cycles
    task automatic serve_frame(input int exp_low, input int ack_dly);
        int n = 0;
        while (req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("req_seen", 32'(req), 32'd1);
        if (exp_low >= 0) check("req_latency", 32'(n), 32'(exp_low));
        check("sel", 32'(sel), 32'(1) << exp_idx);
        check("seg", 32'(seg), 32'(ref_seg(exp_idx)));
        check("busy", 32'(busy), 32'd1);
        repeat (ack_dly) tick();
        check("req_hold", 32'(req), 32'd1);
        check("seg_hold", 32'(seg), 32'(ref_seg(exp_idx)));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("req_drop", 32'(req), 32'd0);
        if (exp_idx == DIGITS - 1) begin
            exp_idx = 0;
            take_snap();
        end else begin
            exp_idx++;
        end
    endtask

    // Drop enable while dwelling; expect IDLE next cycle and blank outputs the cycle after
    task automatic stop_scan();
        en = 1'b0;
        tick();
        check("stop_busy", 32'(busy), 32'd0);
        tick();
        check("stop_sel", 32'(sel), 32'd0);
        check("stop_seg", 32'(seg), 32'hFF);
        check("stop_req", 32'(req), 32'd0);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(req), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        ack      = 1'b0;
        data     = 24'h0;
        dp_mask  = 6'h0;
        blank_lz = 1'b0;
        exp_idx  = 0;
        tick();
        tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Basic scan through a full wrap; later frames also check the dwell gap
        data = 24'h123456;
        start_scan();
        serve_frame(2, 3);
        for (int f = 1; f < 8; f++) serve_frame(SCAN_DIV + 1, 3);
        stop_scan();

        // Leading-zero blanking with decimal points on a blanked and an unblanked digit
        data     = 24'h000705;
        dp_mask  = 6'b000100;
        blank_lz = 1'b1;
        start_scan();
        serve_frame(2, 1);
        for (int f = 1; f < 6; f++) serve_frame(SCAN_DIV + 1, 1);
        stop_scan();
        dp_mask = 6'b010000;
        start_scan();
        serve_frame(2, 0);
        for (int f = 1; f < 6; f++) serve_frame(SCAN_DIV + 1, 2);
        stop_scan();

        // Mid-frame data change stays invisible until the wrap
        data     = 24'hABCDEF;
        dp_mask  = 6'b000000;
        blank_lz = 1'b0;
        start_scan();
        serve_frame(2, 1);
        serve_frame(SCAN_DIV + 1, 1);
        data    = 24'h0F1E2D;
        dp_mask = 6'b101010;
        for (int f = 2; f < 9; f++) serve_frame(SCAN_DIV + 1, 1);
        stop_scan();

        // Randomized digits, decimal points and blanking, with random handshake delays
        for (int it = 0; it < 4; it++) begin
            data     = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
            dp_mask  = 6'($urandom);
            blank_lz = 1'($urandom);
            start_scan();
            serve_frame(2, int'($urandom_range(0, 4)));
            for (int f = 1; f < 7; f++) serve_frame(SCAN_DIV + 1, int'($urandom_range(0, 4)));
            stop_scan();
        end

        // Enable dropped while a request is pending: handshake completes, then idle
        data     = 24'h987654;
        dp_mask  = 6'b000001;
        blank_lz = 1'b0;
        start_scan();
        wait_req("req_pend_seen");
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("req_pend_hold", 32'(req), 32'd1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("req_pend_drop", 32'(req), 32'd0);
        check("req_pend_busy", 32'(busy), 32'd0);
        tick();
        check("req_pend_sel", 32'(sel), 32'd0);
        check("req_pend_seg", 32'(seg), 32'hFF);

        // Stray ack while dwelling must not shift the next request
        start_scan();
        serve_frame(2, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("stray_busy", 32'(busy), 32'd1);
        check("stray_req", 32'(req), 32'd0);
        serve_frame(SCAN_DIV, 2);
        stop_scan();

        // Reset during a pending request
        start_scan();
        wait_req("rst_req_seen");
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("midrst_req", 32'(req), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
